// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: load/store unit for the MEM stage of the 5-stage RV32IM pipeline.
// For each access it runs one request/response transaction on the data-memory bus.
// It formats store byte enables and write data, and sign- or zero-extends load data.
// While an access is outstanding it stalls the pipeline.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   mem_*_i              EX/MEM register: address, store data, funct3, read/write
//   dmem_*_o             registered data-memory request (req, we, addr, wdata, be)
//   dmem_ready_i/rdata_i response strobe and read word
//   lsu_stall_o          combinational freeze of IF..EX/MEM
//   lsu_load_data_o      registered, extended load result for MEM/WB
//   lsu_fault_o/cause_o  one-cycle fault pulse; cause held until the next fault
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_alu_result_i,
  input  logic [31:0] mem_rs2_data_i,
  input  logic [2:0]  mem_funct3_i,
  input  logic        mem_mem_read_i,
  input  logic        mem_mem_write_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        lsu_stall_o,
  output logic [31:0] lsu_load_data_o,
  output logic        lsu_fault_o,
  output logic [1:0]  lsu_fault_cause_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  // Last counter value before the timeout fires (wraps when the timeout is disabled; guarded below).
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q;
  logic [1:0]  lo_q;      // byte offset of the outstanding access
  logic [2:0]  f3_q;      // funct3 of the outstanding access

  logic        is_acc, illegal, misal, go, bad, timeout_hit;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, sh_rdata, load_fmt;

  // Access classification, evaluated only when IDLE
  always_comb begin
    is_acc  = mem_mem_read_i | mem_mem_write_i;
    if (mem_mem_write_i)
      illegal = !(mem_funct3_i inside {3'b000, 3'b001, 3'b010});
    else
      illegal = !(mem_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    // The low two funct3 bits carry the size for all legal encodings.
    misal   = ((mem_funct3_i[1:0] == 2'b01) && mem_alu_result_i[0]) ||
              ((mem_funct3_i[1:0] == 2'b10) && (mem_alu_result_i[1:0] != 2'b00));
    go      = (state_q == S_IDLE) && is_acc && !illegal && !misal;
    bad     = (state_q == S_IDLE) && is_acc && (illegal || misal);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. A ready in the final WAIT cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_WAIT;
      S_WAIT:  if (dmem_ready_i || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and formatting logic
  always_comb begin
    lsu_stall_o = go || (state_q == S_WAIT);
    case (mem_funct3_i[1:0])
      2'b00:   begin be_d = 4'b0001 << mem_alu_result_i[1:0]; wdata_d = {4{mem_rs2_data_i[7:0]}};  end
      2'b01:   begin be_d = 4'b0011 << mem_alu_result_i[1:0]; wdata_d = {2{mem_rs2_data_i[15:0]}}; end
      default: begin be_d = 4'b1111;                          wdata_d = mem_rs2_data_i;             end
    endcase
    // Loads use the registered offset and funct3, so they do not depend on the frozen inputs.
    sh_rdata = dmem_rdata_i >> {lo_q, 3'b000};
    case (f3_q)
      3'b000:  load_fmt = {{24{sh_rdata[7]}},  sh_rdata[7:0]};
      3'b001:  load_fmt = {{16{sh_rdata[15]}}, sh_rdata[15:0]};
      3'b100:  load_fmt = {24'd0, sh_rdata[7:0]};
      3'b101:  load_fmt = {16'd0, sh_rdata[15:0]};
      default: load_fmt = sh_rdata;
    endcase
  end

  // Bus, result and fault registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req_o        <= 1'b0;
      dmem_we_o         <= 1'b0;
      dmem_addr_o       <= '0;
      dmem_wdata_o      <= '0;
      dmem_be_o         <= '0;
      lsu_load_data_o   <= '0;
      lsu_fault_o       <= 1'b0;
      lsu_fault_cause_o <= 2'b00;
      cnt_q             <= '0;
      lo_q              <= '0;
      f3_q              <= '0;
    end else begin
      lsu_fault_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= mem_mem_write_i;
            dmem_addr_o  <= {mem_alu_result_i[31:2], 2'b00};
            dmem_wdata_o <= wdata_d;
            dmem_be_o    <= be_d;
            lo_q         <= mem_alu_result_i[1:0];
            f3_q         <= mem_funct3_i;
            cnt_q        <= '0;
          end else if (bad) begin
            // An illegal funct3 has no defined size, so it reports before misalignment.
            lsu_fault_o       <= 1'b1;
            lsu_fault_cause_o <= illegal ? 2'b10 : 2'b01;
            lsu_load_data_o   <= '0;
          end
        end
        S_WAIT: begin
          if (dmem_ready_i) begin
            dmem_req_o <= 1'b0;
            if (!dmem_we_o) lsu_load_data_o <= load_fmt;
          end else if (timeout_hit) begin
            dmem_req_o        <= 1'b0;
            lsu_fault_o       <= 1'b1;
            lsu_fault_cause_o <= 2'b11;
            lsu_load_data_o   <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu (TIMEOUT_CYCLES=4).
// A table of access vectors is driven, and the expected completion results are queued.
// Each entry is popped and compared when the DONE cycle or the fault pulse appears.
// Hand-written sequences cover the following cases:
//   - a ready pulse while IDLE
//   - a held misaligned access
//   - reset in the middle of WAIT
module tb_mem_stage_lsu;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_alu_result_i = '0, mem_rs2_data_i = '0;
  logic [2:0]  mem_funct3_i = '0;
  logic        mem_mem_read_i = 1'b0, mem_mem_write_i = 1'b0;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ready_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        lsu_stall_o;
  logic [31:0] lsu_load_data_o;
  logic        lsu_fault_o;
  logic [1:0]  lsu_fault_cause_o;

  mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_alu_result_i(mem_alu_result_i), .mem_rs2_data_i(mem_rs2_data_i),
    .mem_funct3_i(mem_funct3_i), .mem_mem_read_i(mem_mem_read_i),
    .mem_mem_write_i(mem_mem_write_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i),
    .lsu_stall_o(lsu_stall_o), .lsu_load_data_o(lsu_load_data_o),
    .lsu_fault_o(lsu_fault_o), .lsu_fault_cause_o(lsu_fault_cause_o)
  );

  always #5 clk = ~clk;

  // kind: 0 completes on ready in WAIT cycle k, 1 faults in IDLE, 2 times out
  typedef struct {
    logic [31:0] addr, rs2;
    logic [2:0]  f3;
    logic        rd, wr;
    logic [31:0] rdata;
    int          k, kind;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we;
    logic [31:0] e_load;
    logic [1:0]  e_cause;
  } vec_t;

  typedef struct {
    logic [31:0] load;
    logic        fault;
    logic [1:0]  cause;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[$];
  int   n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, rs2, input logic [2:0] f3,
                              input logic rd, wr, input logic [31:0] rdata, input int k, kind,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic e_we,
                              input logic [31:0] e_load, input logic [1:0] e_cause);
    vec_t v;
    v.addr = addr; v.rs2 = rs2; v.f3 = f3; v.rd = rd; v.wr = wr; v.rdata = rdata;
    v.k = k; v.kind = kind; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
    v.e_we = e_we; v.e_load = e_load; v.e_cause = e_cause;
    return v;
  endfunction

  task automatic clear_inputs();
    mem_mem_read_i = 1'b0; mem_mem_write_i = 1'b0;
    mem_alu_result_i = '0; mem_rs2_data_i = '0; mem_funct3_i = '0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    sb_t e, got;
    int  c, reqc, stallc, exp_req;
    @(negedge clk);
    mem_alu_result_i = v.addr; mem_rs2_data_i = v.rs2; mem_funct3_i = v.f3;
    mem_mem_read_i = v.rd; mem_mem_write_i = v.wr;
    e.load = v.e_load; e.fault = (v.kind != 0); e.cause = v.e_cause;
    sb.push_back(e);
    #1;
    chk({tag, " stall_c0"}, 32'(lsu_stall_o), 32'(v.kind != 1));
    if (v.kind == 1) begin
      chk({tag, " no_req"}, 32'(dmem_req_o), 32'd0);
      @(negedge clk);
      clear_inputs();
      #1;
      got = sb.pop_front();
      chk({tag, " fault"}, 32'(lsu_fault_o), 32'(got.fault));
      chk({tag, " cause"}, 32'(lsu_fault_cause_o), 32'(got.cause));
      chk({tag, " load"}, lsu_load_data_o, got.load);
      chk({tag, " no_req_c1"}, 32'(dmem_req_o), 32'd0);
      @(negedge clk); #1;
      chk({tag, " fault_1cyc"}, 32'(lsu_fault_o), 32'd0);
      return;
    end
    stallc = 1;
    @(negedge clk); #1;
    chk({tag, " req"}, 32'(dmem_req_o), 32'd1);
    chk({tag, " we"}, 32'(dmem_we_o), 32'(v.e_we));
    chk({tag, " addr"}, dmem_addr_o, v.e_addr);
    chk({tag, " be"}, 32'(dmem_be_o), 32'(v.e_be));
    if (v.e_we) chk({tag, " wdata"}, dmem_wdata_o, v.e_wdata);
    c = 1; reqc = 0;
    while (dmem_req_o === 1'b1 && c < 60) begin
      reqc++;
      if (lsu_stall_o) stallc++;
      dmem_ready_i = (c == v.k);
      dmem_rdata_i = (c == v.k) ? v.rdata : $urandom;
      @(negedge clk);
      dmem_ready_i = 1'b0;
      #1;
      c++;
    end
    if (c >= 60) begin
      n_vec++; n_err++;
      $display("FAIL %s: request still high after 60 cycles", tag);
    end
    // DONE cycle: the access is still on the inputs but must not stall.
    exp_req = (v.kind == 2) ? TO : v.k;
    chk({tag, " done_stall"}, 32'(lsu_stall_o), 32'd0);
    chk({tag, " req_cycles"}, 32'(reqc), 32'(exp_req));
    chk({tag, " stall_cycles"}, 32'(stallc), 32'(exp_req + 1));
    got = sb.pop_front();
    chk({tag, " load"}, lsu_load_data_o, got.load);
    chk({tag, " fault"}, 32'(lsu_fault_o), 32'(got.fault));
    if (got.fault) chk({tag, " cause"}, 32'(lsu_fault_cause_o), 32'(got.cause));
    clear_inputs();
  endtask

  initial begin
    vec_t v;
    //        addr          rs2           f3     rd wr rdata         k kind e_addr        be       e_wdata       we e_load        cause
    vecs.push_back(mk(32'h100, 32'h0,        3'b010,1,0,32'h87654321,3,0, 32'h100,4'b1111,32'h0,        0,32'h87654321,2'b00));
    vecs.push_back(mk(32'h103, 32'h0,        3'b000,1,0,32'h80123456,1,0, 32'h100,4'b1000,32'h0,        0,32'hFFFFFF80,2'b00));
    vecs.push_back(mk(32'h103, 32'h0,        3'b100,1,0,32'h80ABCDEF,2,0, 32'h100,4'b1000,32'h0,        0,32'h00000080,2'b00));
    vecs.push_back(mk(32'h102, 32'h0,        3'b101,1,0,32'hBEEF0000,1,0, 32'h100,4'b1100,32'h0,        0,32'h0000BEEF,2'b00));
    vecs.push_back(mk(32'h201, 32'h123456AB, 3'b000,0,1,32'h0,       1,0, 32'h200,4'b0010,32'hABABABAB, 1,32'h0000BEEF,2'b00));
    vecs.push_back(mk(32'h202, 32'h123456AB, 3'b001,0,1,32'h0,       2,0, 32'h200,4'b1100,32'h56AB56AB, 1,32'h0000BEEF,2'b00));
    vecs.push_back(mk(32'h300, 32'hDEADBEEF, 3'b010,0,1,32'h0,       4,0, 32'h300,4'b1111,32'hDEADBEEF, 1,32'h0000BEEF,2'b00));
    vecs.push_back(mk(32'h106, 32'h0,        3'b001,1,0,32'h80011234,2,0, 32'h104,4'b1100,32'h0,        0,32'hFFFF8001,2'b00));
    vecs.push_back(mk(32'h100, 32'h0,        3'b000,1,0,32'h1234567F,1,0, 32'h100,4'b0001,32'h0,        0,32'h0000007F,2'b00));
    vecs.push_back(mk(32'h102, 32'h0,        3'b010,1,0,32'h0,       0,1, 32'h0,  4'b0000,32'h0,        0,32'h0,       2'b01));
    vecs.push_back(mk(32'h100, 32'h0,        3'b011,1,0,32'h0,       0,1, 32'h0,  4'b0000,32'h0,        0,32'h0,       2'b10));
    vecs.push_back(mk(32'h203, 32'h5555,     3'b001,0,1,32'h0,       0,1, 32'h0,  4'b0000,32'h0,        0,32'h0,       2'b01));
    vecs.push_back(mk(32'h200, 32'h5555,     3'b100,0,1,32'h0,       0,1, 32'h0,  4'b0000,32'h0,        0,32'h0,       2'b10));
    vecs.push_back(mk(32'h400, 32'hCAFEF00D, 3'b010,1,1,32'h0,       2,0, 32'h400,4'b1111,32'hCAFEF00D, 1,32'h0,       2'b00));
    vecs.push_back(mk(32'h500, 32'h0,        3'b010,1,0,32'h0,       0,2, 32'h500,4'b1111,32'h0,        0,32'h0,       2'b11));

    // Reset state, then stall from a legal access present during reset
    #12;
    chk("rst req", 32'(dmem_req_o), 32'd0);
    chk("rst we", 32'(dmem_we_o), 32'd0);
    chk("rst addr", dmem_addr_o, 32'd0);
    chk("rst wdata", dmem_wdata_o, 32'd0);
    chk("rst be", 32'(dmem_be_o), 32'd0);
    chk("rst load", lsu_load_data_o, 32'd0);
    chk("rst fault", 32'(lsu_fault_o), 32'd0);
    chk("rst cause", 32'(lsu_fault_cause_o), 32'd0);
    chk("rst stall idle", 32'(lsu_stall_o), 32'd0);
    mem_mem_read_i = 1'b1; mem_funct3_i = 3'b010; mem_alu_result_i = 32'h100;
    #1 chk("rst stall legal", 32'(lsu_stall_o), 32'd1);
    mem_alu_result_i = 32'h101;
    #1 chk("rst stall misal", 32'(lsu_stall_o), 32'd0);
    clear_inputs();
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // A ready pulse while IDLE is ignored; the timeout then repeats exactly.
    @(negedge clk);
    dmem_ready_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    dmem_ready_i = 1'b0;
    #1;
    chk("idle_ready req", 32'(dmem_req_o), 32'd0);
    chk("idle_ready load", lsu_load_data_o, 32'd0);
    chk("idle_ready stall", 32'(lsu_stall_o), 32'd0);
    run_vec(vecs[14], "timeout2");

    // A misaligned access held for 3 cycles gives one pulse per cycle.
    @(negedge clk);
    mem_mem_read_i = 1'b1; mem_funct3_i = 3'b001; mem_alu_result_i = 32'h301;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("held_misal fault%0d", i), 32'(lsu_fault_o), 32'd1);
      chk($sformatf("held_misal cause%0d", i), 32'(lsu_fault_cause_o), 32'd1);
    end
    clear_inputs();
    @(negedge clk); #1;
    chk("held_misal end", 32'(lsu_fault_o), 32'd0);

    // Reset in WAIT: request and stall drop at once, and a stale ready is ignored.
    @(negedge clk);
    mem_mem_read_i = 1'b1; mem_funct3_i = 3'b010; mem_alu_result_i = 32'h600;
    @(negedge clk); #1;
    chk("rstwait req", 32'(dmem_req_o), 32'd1);
    @(negedge clk);
    clear_inputs();
    #1 chk("rstwait stall", 32'(lsu_stall_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstwait req drop", 32'(dmem_req_o), 32'd0);
    chk("rstwait stall drop", 32'(lsu_stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ready_i = 1'b1; dmem_rdata_i = 32'h11111111;
    @(negedge clk);
    dmem_ready_i = 1'b0;
    #1;
    chk("stale_ready req", 32'(dmem_req_o), 32'd0);
    chk("stale_ready load", lsu_load_data_o, 32'd0);
    chk("stale_ready stall", 32'(lsu_stall_o), 32'd0);
    v = mk(32'h700, 32'h0, 3'b010, 1, 0, 32'h0BADCAFE, 2, 0, 32'h700, 4'b1111, 32'h0, 0,
           32'h0BADCAFE, 2'b00);
    run_vec(v, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
